// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM controller slice.
//   cmd_e      - {cs_n,ras_n,cas_n,we_n} command encodings
//   state_e    - controller FSM states
//   AP_BIT     - address bit carrying auto-precharge / precharge-all
//   MRS_*      - mode register field positions
//   mrs_word() - mode register value for a given CAS latency
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_NOP   = 4'b0111
  } cmd_e;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF,
    ST_INIT_MRS,
    ST_IDLE,
    ST_REFRESH,
    ST_ACTIVATE,
    ST_RW,
    ST_POST_WAIT
  } state_e;

  localparam int AP_BIT     = 10;
  localparam int MRS_BL_LSB = 0;
  localparam int MRS_BT_BIT = 3;
  localparam int MRS_CL_LSB = 4;
  localparam int MRS_WB_BIT = 9;

  // Burst length 1, sequential, single-location writes.
  function automatic logic [15:0] mrs_word(input int unsigned cas_lat);
    logic [15:0] w;
    logic [31:0] cl;
    w = '0;
    cl = cas_lat;
    w[MRS_BL_LSB +: 3] = 3'b000;
    w[MRS_BT_BIT]      = 1'b0;
    w[MRS_CL_LSB +: 3] = cl[2:0];
    w[MRS_WB_BIT]      = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/sdram_if.sv
// sdram_if: host-side request / read-return bus of the SDRAM controller.
//   req_valid/req_ready - request handshake (transfer on both high)
//   req_we              - 1 = write, 0 = read
//   req_addr            - {bank,row,col}
//   req_wdata           - write data
//   rd_valid/rd_data    - read return, rd_valid is a 1-cycle pulse
// master = host side, slave = controller side.
interface sdram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 22
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval counter.
//   clk, rst - clock, asynchronous active-high reset
//   en       - counting enabled (controller initialised)
//   clr      - a REF command is being issued this cycle
//   pending  - a refresh is owed; set on counter wrap, cleared by clr
module sdram_refresh_timer #(
  parameter int T_REFI = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic pending
);
  localparam int CW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          wrap;

  always_comb begin
    wrap  = en && (cnt_q == CW'(T_REFI - 1));
    cnt_d = cnt_q;
    if (en) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    // A wrap coinciding with a clear starts a fresh owed refresh.
    pending_d = (pending_q && !clr) || wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
endmodule

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-access, closed-page SDRAM controller.
//   clk, rst      - clock, asynchronous active-high reset
//   host          - request/read-return bus (sdram_if.slave)
//   init_done     - power-up sequence complete
//   sdram_cke     - clock enable
//   sdram_*_n     - command pins {cs_n,ras_n,cas_n,we_n}
//   sdram_ba/addr - bank / row, column or mode address
//   sdram_dqm     - byte masks, high until initialised
//   sdram_dq_*    - data pad out / output enable / in
// All pad outputs are registered; every access is ACT, then READ or WRITE
// with auto-precharge, then a fixed recovery wait.
module sdram_ctrl
  import sdram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ROW_W   = 12,
  parameter int COL_W   = 8,
  parameter int BANK_W  = 2,
  parameter int CAS_LAT = 2,
  parameter int T_INIT  = 10000,
  parameter int T_RP    = 2,
  parameter int T_RCD   = 2,
  parameter int T_RFC   = 7,
  parameter int T_REFI  = 780
) (
  input  logic                clk,
  input  logic                rst,
  sdram_if.slave              host,
  output logic                init_done,
  output logic                sdram_cke,
  output logic                sdram_cs_n,
  output logic                sdram_ras_n,
  output logic                sdram_cas_n,
  output logic                sdram_we_n,
  output logic [BANK_W-1:0]   sdram_ba,
  output logic [ROW_W-1:0]    sdram_addr,
  output logic [DATA_W/8-1:0] sdram_dqm,
  output logic [DATA_W-1:0]   sdram_dq_out,
  output logic                sdram_dq_oe,
  input  logic [DATA_W-1:0]   sdram_dq_in
);
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int CNT_W  = $clog2(T_INIT + T_RFC + T_RP + T_RCD + CAS_LAT + 4);
  localparam logic [15:0] MRS_VAL = mrs_word(CAS_LAT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ref2_q, ref2_d;
  logic                we_q, we_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  cmd_e                cmd_q, cmd_d;
  logic [BANK_W-1:0]   ba_q, ba_d;
  logic [ROW_W-1:0]    addr_q, addr_d;
  logic [DATA_W/8-1:0] dqm_q, dqm_d;
  logic                dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                cke_q, cke_d;
  logic                init_done_q, init_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic refresh_pending;
  logic ref_issue;
  logic ready;
  logic accept;

  assign ready     = (state_q == ST_IDLE) && init_done_q && !refresh_pending;
  assign accept    = ready && host.req_valid;
  assign ref_issue = (state_q == ST_IDLE) && refresh_pending;

  sdram_refresh_timer #(
    .T_REFI(T_REFI)
  ) u_refresh_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (init_done_q),
    .clr    (ref_issue),
    .pending(refresh_pending)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    ref2_d      = ref2_q;
    we_d        = we_q;
    col_d       = col_q;
    wdata_d     = wdata_q;
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    addr_d      = addr_q;
    dqm_d       = dqm_q;
    dq_oe_d     = 1'b0;
    dq_out_d    = '0;
    cke_d       = 1'b1;
    init_done_d = init_done_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_q == CNT_W'(T_INIT - 1)) begin
          cmd_d          = CMD_PRE;
          ba_d           = '0;
          addr_d         = '0;
          addr_d[AP_BIT] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_INIT_PRE;
        end
      end
      ST_INIT_PRE: begin
        if (cnt_q == CNT_W'(T_RP - 1)) begin
          cmd_d   = CMD_REF;
          ref2_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_INIT_REF;
        end
      end
      ST_INIT_REF: begin
        // Init commands after a REF are spaced T_RFC+2 cycles apart.
        if (cnt_q == CNT_W'(T_RFC + 1)) begin
          cnt_d = '0;
          if (!ref2_q) begin
            cmd_d  = CMD_REF;
            ref2_d = 1'b1;
          end else begin
            cmd_d   = CMD_MRS;
            ba_d    = '0;
            addr_d  = MRS_VAL[ROW_W-1:0];
            state_d = ST_INIT_MRS;
          end
        end
      end
      ST_INIT_MRS: begin
        if (cnt_q == CNT_W'(1)) begin
          init_done_d = 1'b1;
          dqm_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (ref_issue) begin
          cmd_d   = CMD_REF;
          state_d = ST_REFRESH;
        end else if (accept) begin
          cmd_d   = CMD_ACT;
          ba_d    = host.req_addr[ADDR_W-1 -: BANK_W];
          addr_d  = host.req_addr[COL_W +: ROW_W];
          col_d   = host.req_addr[COL_W-1:0];
          we_d    = host.req_we;
          wdata_d = host.req_wdata;
          state_d = ST_ACTIVATE;
        end
      end
      ST_REFRESH: begin
        if (cnt_q == CNT_W'(T_RFC - 1)) state_d = ST_IDLE;
      end
      ST_ACTIVATE: begin
        if (cnt_q == CNT_W'(T_RCD - 1)) begin
          cmd_d             = we_q ? CMD_WRITE : CMD_READ;
          addr_d            = '0;
          addr_d[COL_W-1:0] = col_q;
          addr_d[AP_BIT]    = 1'b1;
          dq_oe_d           = we_q;
          dq_out_d          = we_q ? wdata_q : '0;
          state_d           = ST_RW;
        end
      end
      ST_RW: begin
        cnt_d   = '0;
        state_d = ST_POST_WAIT;
      end
      ST_POST_WAIT: begin
        // Pad data of a READ is valid CAS_LAT cycles after the command.
        if (!we_q && cnt_q == CNT_W'(CAS_LAT - 1)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = sdram_dq_in;
        end
        if (cnt_q == CNT_W'(T_RP + CAS_LAT)) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT_WAIT;
      cnt_q       <= '0;
      ref2_q      <= 1'b0;
      we_q        <= 1'b0;
      col_q       <= '0;
      wdata_q     <= '0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      addr_q      <= '0;
      dqm_q       <= '1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      cke_q       <= 1'b0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref2_q      <= ref2_d;
      we_q        <= we_d;
      col_q       <= col_d;
      wdata_q     <= wdata_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      dqm_q       <= dqm_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      cke_q       <= cke_d;
      init_done_q <= init_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_ba       = ba_q;
  assign sdram_addr     = addr_q;
  assign sdram_dqm      = dqm_q;
  assign sdram_dq_oe    = dq_oe_q;
  assign sdram_dq_out   = dq_out_q;
  assign sdram_cke      = cke_q;
  assign init_done      = init_done_q;
  assign host.req_ready = ready;
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;
endmodule
